// File: rtl/object_slot_scheduler_pkg.sv
// ============================================================================
// Module      : object_slot_scheduler_pkg
// Description : Shared constants for the attack-object collider pool.
//               - Pool geometry: slot count, slot index width, destroy-timer
//                 width.
//               - Destroy-time encoding: a destroy time of TIME_PERMANENT
//                 marks a slot that never expires.
//               - Scheduler FSM state encoding.
//               The geometry and encoding are also consumed by the collider
//               runtime and the attack-object reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package object_slot_scheduler_pkg;

    // Pool geometry. Keep 2**OBJPOOL_IDX_W >= OBJPOOL_SLOT_COUNT.
    localparam int OBJPOOL_SLOT_COUNT = 30;
    localparam int OBJPOOL_IDX_W      = 5;
    localparam int OBJPOOL_TIME_W     = 8;

    // Destroy-time value that means "never expires".
    localparam int TIME_PERMANENT = 0;

    // Scheduler FSM states.
    localparam logic [0:0] c_st_run   = 1'b0;
    localparam logic [0:0] c_st_clear = 1'b1;

endpackage

`default_nettype wire

// File: rtl/object_slot_scheduler_slot_rr_finder.sv
// ============================================================================
// Module      : slot_rr_finder
// Description : Combinational rotating-priority search for a free slot.
//               Finds the first index with slot_busy == 0, searching upward
//               from rr_ptr and wrapping from SLOT_COUNT-1 back to 0.
// Ports       : slot_busy - occupancy vector
//               rr_ptr    - search start index (always < SLOT_COUNT)
//               found     - at least one slot is free
//               index     - first free slot; equals rr_ptr when none is free
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slot_rr_finder
    import object_slot_scheduler_pkg::*;
#(
    parameter int SLOT_COUNT = OBJPOOL_SLOT_COUNT,
    parameter int IDX_W      = OBJPOOL_IDX_W
) (
    input  logic [SLOT_COUNT-1:0] slot_busy,
    input  logic [IDX_W-1:0]      rr_ptr,
    output logic                  found,
    output logic [IDX_W-1:0]      index
);

    localparam logic [IDX_W:0] c_slot_count = (IDX_W+1)'(SLOT_COUNT);

    // Walk the offsets from farthest to nearest so that the last free slot
    // written is the one closest to rr_ptr; no early-exit flag is needed.
    always_comb begin
        logic [IDX_W:0] w_cand;
        found  = |(~slot_busy);
        index  = rr_ptr;
        w_cand = '0;
        for (int k = SLOT_COUNT - 1; k >= 0; k--) begin
            w_cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (w_cand >= c_slot_count) begin
                w_cand = w_cand - c_slot_count;
            end
            if (!slot_busy[w_cand[IDX_W-1:0]]) begin
                index = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/object_slot_scheduler.sv
// ============================================================================
// Module      : object_slot_scheduler
// Description : Grants collider-pool slots to spawn requests, runs a per-slot
//               destroy countdown on the centi-second tick, and frees slots on
//               expiry, external release or stage clear.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               clk_centi_second    - one-cycle tick every 10 ms
//               clear_all           - stage reset, frees every slot silently
//               spawn_valid         - spawn request
//               spawn_destroy_time  - lifetime in ticks (0 = permanent)
//               spawn_ready         - a slot can be granted this cycle
//               spawn_slot          - slot granted if the request fires
//               load_pulse          - one-hot, cycle after a grant
//               release_req         - per-slot kill request
//               slot_busy           - registered occupancy
//               free_pulse          - one-hot pulses on expiry/release frees
//               free_count          - registered number of free slots
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module object_slot_scheduler
    import object_slot_scheduler_pkg::*;
#(
    parameter int SLOT_COUNT = OBJPOOL_SLOT_COUNT,
    parameter int IDX_W      = OBJPOOL_IDX_W,
    parameter int TIME_W     = OBJPOOL_TIME_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_centi_second,
    input  logic                  clear_all,
    input  logic                  spawn_valid,
    input  logic [TIME_W-1:0]     spawn_destroy_time,
    output logic                  spawn_ready,
    output logic [IDX_W-1:0]      spawn_slot,
    output logic [SLOT_COUNT-1:0] load_pulse,
    input  logic [SLOT_COUNT-1:0] release_req,
    output logic [SLOT_COUNT-1:0] slot_busy,
    output logic [SLOT_COUNT-1:0] free_pulse,
    output logic [IDX_W:0]        free_count
);

    localparam logic [IDX_W:0]    c_slot_count = (IDX_W+1)'(SLOT_COUNT);
    localparam logic [IDX_W:0]    c_cnt_one    = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0]  c_last_slot  = IDX_W'(SLOT_COUNT - 1);
    localparam logic [IDX_W-1:0]  c_idx_one    = IDX_W'(1);
    localparam logic [TIME_W-1:0] c_time_perm  = TIME_W'(TIME_PERMANENT);
    localparam logic [TIME_W-1:0] c_time_one   = TIME_W'(1);

    logic [SLOT_COUNT-1:0] r_busy;
    logic [TIME_W-1:0]     r_timer [SLOT_COUNT];
    logic [IDX_W-1:0]      r_rr;
    logic [SLOT_COUNT-1:0] r_load;
    logic [SLOT_COUNT-1:0] r_free;
    logic [IDX_W:0]        r_free_count;
    logic [0:0]            r_state;

    logic                  w_found;
    logic [IDX_W-1:0]      w_cand;
    logic                  w_grant;
    logic [SLOT_COUNT-1:0] w_busy_nxt;
    logic [TIME_W-1:0]     w_timer_nxt [SLOT_COUNT];
    logic [IDX_W-1:0]      w_rr_nxt;
    logic [SLOT_COUNT-1:0] w_load_nxt;
    logic [SLOT_COUNT-1:0] w_free_nxt;
    logic [IDX_W:0]        w_free_count_nxt;
    logic [0:0]            w_state_nxt;

    slot_rr_finder #(
        .SLOT_COUNT (SLOT_COUNT),
        .IDX_W      (IDX_W)
    ) u_finder (
        .slot_busy (r_busy),
        .rr_ptr    (r_rr),
        .found     (w_found),
        .index     (w_cand)
    );

    // The cycle after a clear (CLEAR state) blocks grants so the requester
    // sees a clean, fully free pool before the first new spawn.
    assign spawn_ready = w_found && !clear_all && (r_state == c_st_run);
    assign spawn_slot  = w_cand;
    assign w_grant     = spawn_valid && spawn_ready;
    assign w_state_nxt = clear_all ? c_st_clear : c_st_run;

    always_comb begin
        w_busy_nxt  = r_busy;
        w_timer_nxt = r_timer;
        w_rr_nxt    = r_rr;
        w_load_nxt  = '0;
        w_free_nxt  = '0;
        if (clear_all) begin
            w_busy_nxt = '0;
            w_rr_nxt   = '0;
            for (int i = 0; i < SLOT_COUNT; i++) begin
                w_timer_nxt[i] = '0;
            end
        end else begin
            // Frees and countdowns look only at currently busy slots. The
            // granted slot is free right now, so it never overlaps with a
            // free or a decrement on the same edge.
            for (int i = 0; i < SLOT_COUNT; i++) begin
                if (r_busy[i]) begin
                    if (release_req[i] ||
                        (clk_centi_second && r_timer[i] == c_time_one)) begin
                        w_busy_nxt[i]  = 1'b0;
                        w_timer_nxt[i] = '0;
                        w_free_nxt[i]  = 1'b1;
                    end else if (clk_centi_second && r_timer[i] != c_time_perm) begin
                        w_timer_nxt[i] = r_timer[i] - c_time_one;
                    end
                end
            end
            if (w_grant) begin
                w_busy_nxt[w_cand]  = 1'b1;
                w_timer_nxt[w_cand] = spawn_destroy_time;
                w_load_nxt[w_cand]  = 1'b1;
                w_rr_nxt = (w_cand == c_last_slot) ? '0 : w_cand + c_idx_one;
            end
        end
    end

    always_comb begin
        w_free_count_nxt = '0;
        for (int i = 0; i < SLOT_COUNT; i++) begin
            if (!w_busy_nxt[i]) begin
                w_free_count_nxt = w_free_count_nxt + c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy       <= '0;
            r_timer      <= '{default: '0};
            r_rr         <= '0;
            r_load       <= '0;
            r_free       <= '0;
            r_free_count <= c_slot_count;
            r_state      <= c_st_run;
        end else begin
            r_busy       <= w_busy_nxt;
            r_timer      <= w_timer_nxt;
            r_rr         <= w_rr_nxt;
            r_load       <= w_load_nxt;
            r_free       <= w_free_nxt;
            r_free_count <= w_free_count_nxt;
            r_state      <= w_state_nxt;
        end
    end

    assign slot_busy  = r_busy;
    assign load_pulse = r_load;
    assign free_pulse = r_free;
    assign free_count = r_free_count;

endmodule

`default_nettype wire

// File: tb/tb_object_slot_scheduler.sv
// ============================================================================
// Module      : tb_object_slot_scheduler
// Description : Self-checking bench for object_slot_scheduler: directed
//               scenarios with literal expectations, then random traffic,
//               all compared each cycle against a pool model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_object_slot_scheduler;

    localparam int SC = 30;
    localparam int IW = 5;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic          clear_all = 1'b0;
    logic          spawn_valid = 1'b0;
    logic [TW-1:0] destroy = '0;
    logic [SC-1:0] release_req = '0;
    logic          spawn_ready;
    logic [IW-1:0] spawn_slot;
    logic [SC-1:0] load_pulse;
    logic [SC-1:0] slot_busy;
    logic [SC-1:0] free_pulse;
    logic [IW:0]   free_count;

    object_slot_scheduler dut (
        .clk                (clk),
        .reset              (reset),
        .clk_centi_second   (tick),
        .clear_all          (clear_all),
        .spawn_valid        (spawn_valid),
        .spawn_destroy_time (destroy),
        .spawn_ready        (spawn_ready),
        .spawn_slot         (spawn_slot),
        .load_pulse         (load_pulse),
        .release_req        (release_req),
        .slot_busy          (slot_busy),
        .free_pulse         (free_pulse),
        .free_count         (free_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Pool model: occupancy set, remaining lifetime per slot, search start.
    // ------------------------------------------------------------------
    logic [SC-1:0] m_busy = '0;
    logic [SC-1:0] m_load = '0;
    logic [SC-1:0] m_free = '0;
    int            m_timer [SC];
    int            m_rr = 0;
    bit            m_in_clear = 1'b0;
    bit            m_init = 1'b0;

    function automatic int m_cand();
        for (int k = 0; k < SC; k++) begin
            if (!m_busy[(m_rr + k) % SC]) return (m_rr + k) % SC;
        end
        return m_rr;
    endfunction

    function automatic bit m_any_free();
        return $countones(m_busy) < SC;
    endfunction

    always @(posedge clk) begin
        bit grant;
        int slot;
        if (reset) begin
            m_busy = '0; m_load = '0; m_free = '0; m_rr = 0;
            for (int i = 0; i < SC; i++) m_timer[i] = 0;
            m_in_clear = 1'b0;
            m_init = 1'b1;
        end else if (clear_all) begin
            m_busy = '0; m_load = '0; m_free = '0; m_rr = 0;
            for (int i = 0; i < SC; i++) m_timer[i] = 0;
            m_in_clear = 1'b1;
        end else begin
            grant = spawn_valid && m_any_free() && !m_in_clear;
            slot  = m_cand();
            m_load = '0;
            m_free = '0;
            for (int i = 0; i < SC; i++) begin
                if (m_busy[i]) begin
                    if (release_req[i] || (tick && m_timer[i] == 1)) begin
                        m_busy[i] = 1'b0; m_timer[i] = 0; m_free[i] = 1'b1;
                    end else if (tick && m_timer[i] > 1) begin
                        m_timer[i] = m_timer[i] - 1;
                    end
                end
            end
            if (grant) begin
                m_busy[slot]  = 1'b1;
                m_timer[slot] = int'(destroy);
                m_load[slot]  = 1'b1;
                m_rr          = (slot + 1) % SC;
            end
            m_in_clear = 1'b0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit exp_ready;
        if (m_init) begin
            chk("slot_busy",  slot_busy,  m_busy);
            chk("free_count", free_count, 64'(SC - $countones(m_busy)));
            chk("load_pulse", load_pulse, m_load);
            chk("free_pulse", free_pulse, m_free);
            exp_ready = m_any_free() && !clear_all && !m_in_clear;
            chk("spawn_ready", spawn_ready, exp_ready);
            if (exp_ready) chk("spawn_slot", spawn_slot, 64'(m_cand()));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic drive(input bit v, input int dt, input bit tk,
                         input logic [SC-1:0] rel, input bit clr);
        spawn_valid = v;
        destroy     = TW'(dt);
        tick        = tk;
        release_req = rel;
        clear_all   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 1'b0, '0, 1'b0);
    endtask

    function automatic logic [SC-1:0] bit_of(input int i);
        logic [SC-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [SC-1:0] rel;
        bit            seen;

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset and idle.
        idle(10);
        chk("init_free_count", free_count, 30);
        chk("init_busy", slot_busy, 0);
        chk("init_ready", spawn_ready, 1);
        chk("init_slot", spawn_slot, 0);

        // Back-to-back grants yield slots 0,1,2.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5, 1'b0, '0, 1'b0);
            chk("b2b_load", load_pulse, bit_of(k));
        end
        chk("b2b_free_count", free_count, 27);

        // Expiry after 3 ticks; permanent slot survives 50 ticks.
        drive(1'b0, 0, 1'b0, '0, 1'b1);
        idle(2);
        drive(1'b1, 3, 1'b0, '0, 1'b0);
        chk("exp_load", load_pulse, 1);
        drive(1'b0, 0, 1'b1, '0, 1'b0);
        drive(1'b0, 0, 1'b1, '0, 1'b0);
        chk("exp_still_busy", slot_busy, 1);
        drive(1'b0, 0, 1'b1, '0, 1'b0);
        chk("exp_free_pulse", free_pulse, 1);
        chk("exp_busy_clear", slot_busy, 0);
        drive(1'b1, 0, 1'b0, '0, 1'b0);
        repeat (50) drive(1'b0, 0, 1'b1, '0, 1'b0);
        chk("perm_busy", slot_busy, bit_of(1));

        // Fill the pool, stall, then release slot 7.
        drive(1'b0, 0, 1'b0, '0, 1'b1);
        idle(1);
        repeat (30) drive(1'b1, 0, 1'b0, '0, 1'b0);
        chk("full_free_count", free_count, 0);
        drive(1'b1, 0, 1'b0, '0, 1'b0);
        drive(1'b1, 0, 1'b0, '0, 1'b0);
        chk("stall_load", load_pulse, 0);
        chk("stall_ready", spawn_ready, 0);
        drive(1'b1, 0, 1'b0, bit_of(7), 1'b0);
        chk("rel7_free_pulse", free_pulse, bit_of(7));
        chk("rel7_cand", spawn_slot, 7);
        drive(1'b1, 0, 1'b0, '0, 1'b0);
        chk("rel7_regrant", load_pulse, bit_of(7));

        // Release and expiry of slot 4 on the same edge.
        drive(1'b0, 0, 1'b0, '0, 1'b1);
        idle(1);
        repeat (4) drive(1'b1, 0, 1'b0, '0, 1'b0);
        drive(1'b1, 1, 1'b0, '0, 1'b0);
        idle(1);
        chk("dual_pre_count", free_count, 25);
        drive(1'b0, 0, 1'b1, bit_of(4), 1'b0);
        chk("dual_free_pulse", free_pulse, bit_of(4));
        chk("dual_free_count", free_count, 26);

        // Clear with 12 busy slots and a pending request.
        drive(1'b0, 0, 1'b0, '0, 1'b1);
        idle(1);
        repeat (12) drive(1'b1, 0, 1'b0, '0, 1'b0);
        chk("clr_pre_count", free_count, 18);
        drive(1'b1, 0, 1'b0, '0, 1'b1);
        chk("clr_busy", slot_busy, 0);
        chk("clr_free_count", free_count, 30);
        chk("clr_load", load_pulse, 0);
        chk("clr_free_pulse", free_pulse, 0);
        seen = 1'b0;
        for (int n = 0; n < 5 && !seen; n++) begin
            drive(1'b1, 0, 1'b0, '0, 1'b0);
            seen = (load_pulse != '0);
        end
        chk("clr_first_grant", load_pulse, 1);
        idle(2);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            rel = '0;
            for (int i = 0; i < SC; i++) rel[i] = ($urandom_range(0, 47) == 0);
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6)),
                  $urandom_range(0, 3) == 0,
                  rel,
                  $urandom_range(0, 299) == 0);
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/object_slot_scheduler.md
Name: object_slot_scheduler

Overview:
Allocates slots in the fixed-size attack-object collider pool to spawn requests issued by the game runtime. Each granted slot gets a destroy countdown in centi-second ticks, and the block frees slots on expiry, on external release (hit or collision) or on stage clear. It sits between game_runtime_execute / attack_object_reader and multi_object_collider_runtime_execute, and it owns the pool's busy state (object_ready_state is the inverse of slot_busy).

Parameters:
SLOT_COUNT, 30, number of object slots in the pool
IDX_W, 5, slot index width; must satisfy 2**IDX_W >= SLOT_COUNT
TIME_W, 8, destroy-time counter width in centi-seconds

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
clk_centi_second  in  1  one-cycle tick pulse, once per 10 ms
clear_all  in  1  stage reset; frees every slot
spawn_valid  in  1  requester has an object to place
spawn_destroy_time  in  TIME_W  lifetime in ticks; 0 means permanent
spawn_ready  out  1  a free slot is available (combinational)
spawn_slot  out  IDX_W  slot that will be granted this cycle (combinational)
load_pulse  out  SLOT_COUNT  one-hot, one cycle after grant; tells the slot to latch its object data
release_req  in  SLOT_COUNT  per-slot kill request, level sampled each cycle
slot_busy  out  SLOT_COUNT  registered occupancy
free_pulse  out  SLOT_COUNT  one-cycle pulse when a slot frees by expiry or release
free_count  out  IDX_W+1  registered count of free slots

Behaviour:
- Reset values: slot_busy=0, all timers=0, rr_ptr=0, load_pulse=0, free_pulse=0, free_count=SLOT_COUNT.
- Candidate selection: spawn_slot is the first index i with slot_busy[i]=0, searching from rr_ptr upward and wrapping at SLOT_COUNT-1 to 0.
- spawn_ready = (any slot free) && !clear_all.
- When no slot is free, spawn_slot = rr_ptr and is don't-care.
- Grant: spawn_valid && spawn_ready at a clk edge. On that edge:
  - slot_busy[spawn_slot] <= 1
  - timer[spawn_slot] <= spawn_destroy_time
  - rr_ptr <= spawn_slot+1, wrapping to 0 after SLOT_COUNT-1
  - load_pulse <= onehot(spawn_slot)
- Latency: load_pulse is asserted exactly 1 cycle after grant. Back-to-back grants every cycle are legal and must yield distinct slots.
- Stall: when spawn_valid=1 and spawn_ready=0, the requester holds spawn_valid and its data. No drop occurs and no state changes.
- Tick: on clk_centi_second, for each busy slot:
  - timer>1: decrement timer.
  - timer==1: timer <= 0, slot_busy <= 0, free_pulse[i] <= 1.
  - timer==0: permanent slot; no change.
- Release: release_req[i]=1 with slot_busy[i]=1 frees slot i on that edge and pulses free_pulse[i]. release_req on a free slot is ignored.
- Release and expiry on the same slot in the same cycle: exactly one free_pulse.
- A slot being freed this cycle is still busy, so it is never the spawn candidate in the same cycle. The earliest it can be re-granted is the next cycle.
- Grant and tick in the same cycle: the newly granted slot's timer is not decremented on that tick.
- clear_all (highest priority after reset):
  - Next edge: slot_busy=0, timers=0, rr_ptr=0, load_pulse=0.
  - free_pulse stays 0; clears are silent.
  - Grants, ticks and releases in that cycle are ignored.
- free_count is updated on the same edge as slot_busy and equals SLOT_COUNT - popcount(slot_busy).
- FSM is 2 states:
  - RUN: normal operation.
  - CLEAR: entered on clear_all, lasts while clear_all is held plus 1 cycle; spawn_ready=0. Returns to RUN.

Decomposition:
- Shared header objpool_defs.vh holds SLOT_COUNT, IDX_W, TIME_W and the encoding TIME_PERMANENT=0. These are shared with the collider runtime and attack_object_reader.
- Natural sub-module: slot_rr_finder, a combinational rotating priority search taking slot_busy and rr_ptr and producing found and index. It can be unit-tested separately.

Test Plan:
- Reset, then idle 10 cycles -> slot_busy=0, free_count=30, spawn_ready=1, spawn_slot=0, all pulses 0.
- 3 back-to-back spawns (destroy=5) -> slots 0,1,2 granted; load_pulse bits 0,1,2 on consecutive cycles; free_count=27.
- Spawn with destroy=3, then 3 ticks -> free_pulse[0] on the 3rd tick edge, slot_busy[0]=0. Spawn with destroy=0 plus 50 ticks -> slot stays busy.
- 30 spawns -> spawn_ready=0 and the next request stalls. Then release_req[7] -> free_pulse[7]; the stalled request is granted slot 7 next cycle with rr_ptr=0.
- Same cycle: release_req[4] plus a tick expiring slot 4 -> single free_pulse[4], free_count +1 only.
- clear_all with 12 busy slots and spawn_valid high -> no grant or pulse in that cycle; next cycle slot_busy=0, free_count=30; first subsequent grant is slot 0.
